// File: rtl/rgb_channel_packer.sv
// rgb_channel_packer
// Collects channel-tagged samples (R, G, B) into one pixel and presents the
// finished pixel on a valid/ready port. A one-pixel output register plus a
// STALL state absorb downstream backpressure. While a finished pixel waits in
// the accumulator, the channel input is held off through ch_ready.

module rgb_channel_packer #(
    parameter int DATA_WIDTH   = 8,
    parameter bit STRICT_ORDER = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ch_data,
    input  logic [1:0]            ch_sel,
    input  logic                  ch_valid,
    output logic                  ch_ready,
    output logic [DATA_WIDTH-1:0] r_out,
    output logic [DATA_WIDTH-1:0] g_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  dup_err,
    output logic                  sel_err,
    output logic                  seq_err
);

    // FSM encoding: COLLECT accepts beats, STALL holds a finished pixel in acc
    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_STALL   = 1'b1;

    // Channel tags carried on ch_sel
    localparam logic [1:0] SEL_R   = 2'b00;
    localparam logic [1:0] SEL_G   = 2'b01;
    localparam logic [1:0] SEL_B   = 2'b10;
    localparam logic [1:0] SEL_BAD = 2'b11;

    localparam logic [2:0] MASK_NONE = 3'b000;
    localparam logic [2:0] MASK_R    = 3'b001;
    localparam logic [2:0] MASK_FULL = 3'b111;

    logic [0:0]            state;
    logic [2:0]            mask;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] g_acc;
    logic [DATA_WIDTH-1:0] b_acc;

    // Beat decode results
    logic                  beat_accept;
    logic                  pix_drain;
    logic [2:0]            sel_onehot;
    logic [2:0]            expected_onehot;
    logic [2:0]            wr_en;
    logic [2:0]            mask_nxt;
    logic                  dup_nxt;
    logic                  sel_nxt;
    logic                  seq_nxt;
    logic                  complete;

    // Output-register control
    logic                  load_from_beat;
    logic                  load_from_stall;
    logic                  load_out;
    logic                  stall_enter;

    // Accumulator contents as they will be after this edge
    logic [DATA_WIDTH-1:0] r_acc_nxt;
    logic [DATA_WIDTH-1:0] g_acc_nxt;
    logic [DATA_WIDTH-1:0] b_acc_nxt;

    assign beat_accept = ch_valid && ch_ready;
    assign pix_drain   = pix_valid && pix_ready;

    // Decode an accepted beat into write enables, the next mask and error pulses
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        sel_onehot      = MASK_NONE;
        expected_onehot = MASK_NONE;
        wr_en           = MASK_NONE;
        mask_nxt        = mask;
        dup_nxt         = 1'b0;
        sel_nxt         = 1'b0;
        seq_nxt         = 1'b0;

        case (ch_sel)
            SEL_R:   sel_onehot = 3'b001;
            SEL_G:   sel_onehot = 3'b010;
            SEL_B:   sel_onehot = 3'b100;
            default: sel_onehot = MASK_NONE;
        endcase

        // In strict mode the only acceptable channel is the lowest one still missing
        if (!mask[0]) begin
            expected_onehot = 3'b001;
        end else if (!mask[1]) begin
            expected_onehot = 3'b010;
        end else if (!mask[2]) begin
            expected_onehot = 3'b100;
        end

        if (beat_accept) begin
            if (ch_sel == SEL_BAD) begin
                // Illegal tag: drop the sample and leave the partial pixel alone
                sel_nxt = 1'b1;
            end else if (!STRICT_ORDER) begin
                wr_en    = sel_onehot;
                mask_nxt = mask | sel_onehot;
                dup_nxt  = |(mask & sel_onehot);
            end else if (sel_onehot == expected_onehot) begin
                wr_en    = sel_onehot;
                mask_nxt = mask | sel_onehot;
            end else begin
                // Out-of-order beat: abandon the partial pixel. An R can still
                // start a fresh pixel, so it is kept instead of discarded.
                seq_nxt = 1'b1;
                if (ch_sel == SEL_R) begin
                    wr_en    = MASK_R;
                    mask_nxt = MASK_R;
                end else begin
                    mask_nxt = MASK_NONE;
                end
            end
        end

        complete = beat_accept && (mask != MASK_FULL) && (mask_nxt == MASK_FULL);
    end

    // Merge the accepted sample into the accumulator view used for output loads
    always_comb begin
        r_acc_nxt = wr_en[0] ? ch_data : r_acc;
        g_acc_nxt = wr_en[1] ? ch_data : g_acc;
        b_acc_nxt = wr_en[2] ? ch_data : b_acc;
    end

    // Decide whether the output register loads a pixel on this edge
    always_comb begin
        load_from_beat  = (state == ST_COLLECT) && complete && (!pix_valid || pix_ready);
        stall_enter     = (state == ST_COLLECT) && complete && !load_from_beat;
        load_from_stall = (state == ST_STALL) && pix_drain;
        load_out        = load_from_beat || load_from_stall;
    end

    // FSM, channel mask and the registered ch_ready
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state    <= ST_COLLECT;
            mask     <= MASK_NONE;
            ch_ready <= 1'b0;
        end else if (state == ST_COLLECT) begin
            if (stall_enter) begin
                // Finished pixel parks in acc until the output register frees up
                state    <= ST_STALL;
                mask     <= MASK_FULL;
                ch_ready <= 1'b0;
            end else begin
                mask     <= load_from_beat ? MASK_NONE : mask_nxt;
                ch_ready <= 1'b1;
            end
        end else begin
            if (load_from_stall) begin
                state    <= ST_COLLECT;
                mask     <= MASK_NONE;
                ch_ready <= 1'b1;
            end
        end
    end

    // Accumulator capture of accepted channel samples
    always_ff @(posedge clk) begin
        // NOTE: accumulators have no reset; the mask gates every use of them and rst clears the mask.
        r_acc <= r_acc_nxt;
        g_acc <= g_acc_nxt;
        b_acc <= b_acc_nxt;
    end

    // Output pixel register and its valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out     <= '0;
            g_out     <= '0;
            b_out     <= '0;
            pix_valid <= 1'b0;
        end else if (load_out) begin
            // In STALL no beat is accepted, so the *_nxt view equals acc there
            r_out     <= r_acc_nxt;
            g_out     <= g_acc_nxt;
            b_out     <= b_acc_nxt;
            pix_valid <= 1'b1;
        end else if (pix_drain) begin
            pix_valid <= 1'b0;
        end
    end

    // Registered one-cycle error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            dup_err <= 1'b0;
            sel_err <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            dup_err <= dup_nxt;
            sel_err <= sel_nxt;
            seq_err <= seq_nxt;
        end
    end

endmodule

// File: doc/rgb_channel_packer.md
# rgb_channel_packer

Packs a stream of single-channel 8-bit samples, each tagged with its channel, back into full RGB pixels. It is the write-side counterpart of the per-channel extraction stage: it collects R, G and B for one pixel, then presents them together on a valid/ready pixel port. It sits between per-channel processing and any RGB-consuming stage, and absorbs downstream backpressure with a one-pixel output register plus a stall state.

## Interface
- DATA_WIDTH, 8: width of each channel sample and each pixel component.
- STRICT_ORDER, 0: 0 = channels accepted in any order; 1 = channels must arrive R, G, B.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- ch_data  in  DATA_WIDTH  channel sample.
- ch_sel  in  2  channel tag: 00 R, 01 G, 10 B, 11 illegal.
- ch_valid  in  1  ch_data/ch_sel valid.
- ch_ready  out  1  registered; beat accepted when ch_valid && ch_ready.
- r_out, g_out, b_out  out  DATA_WIDTH each  packed pixel.
- pix_valid  out  1  pixel present on r/g/b_out.
- pix_ready  in  1  downstream accepts the pixel when pix_valid && pix_ready.
- dup_err  out  1  one-cycle pulse: channel already held for the current pixel was overwritten.
- sel_err  out  1  one-cycle pulse: beat with ch_sel=11 accepted and discarded.
- seq_err  out  1  one-cycle pulse: out-of-order beat (STRICT_ORDER=1 only).

## Operation
- Accumulator: r_acc, g_acc, b_acc and a 3-bit have mask (bit0 R, bit1 G, bit2 B).
- FSM states: COLLECT (ch_ready=1) and STALL (ch_ready=0). Reset state is COLLECT.
- Accepted beat, ch_sel=11: data dropped, mask unchanged, sel_err pulses.
- Accepted beat, legal channel, STRICT_ORDER=0: the matching acc register is written and its mask bit set. If that bit was already set, the value is overwritten and dup_err pulses.
- STRICT_ORDER=1: the expected channel is the lowest clear mask bit.
  - Expected beat: written as above.
  - Unexpected legal beat: seq_err pulses, the mask clears and the partial pixel is discarded.
  - Exception: if the unexpected beat is R, it is written as the first channel of a new pixel (mask=001).
  - dup_err never fires in this mode.
- Completion: the beat that makes the mask 111 completes the pixel.
  - Output register free (pix_valid=0) or draining this cycle (pix_valid && pix_ready): next edge loads r/g/b_out from acc (including the completing beat), sets pix_valid=1, clears the mask, stays in COLLECT.
  - Otherwise: the pixel is held in acc with mask=111, ch_ready drops to 0 and the FSM moves to STALL.
- STALL: on pix_valid && pix_ready, the output loads acc, pix_valid stays 1, the mask clears, ch_ready returns to 1 and the FSM returns to COLLECT.
- pix_valid clears on pix_valid && pix_ready when no completed pixel is loading on the same edge.
- Output data is stable while pix_valid && !pix_ready.
- No arithmetic on data; all widths are DATA_WIDTH with no truncation.

## Timing
- Reset values (while rst=1 and on the first edge after): r/g/b_out=0, pix_valid=0, ch_ready=0, dup_err=sel_err=seq_err=0, mask=000, state=COLLECT.
- ch_ready goes to 1 on the first edge with rst=0.
- Latency: pix_valid rises on the edge after the completing beat is accepted.
- Throughput: 1 pixel per 3 accepted beats, with no bubble when pix_ready is held high.
- ch_ready is registered; it falls on the same edge the FSM enters STALL.
  - It does not depend combinationally on ch_valid, ch_sel or pix_ready.
  - A beat offered while ch_ready=0 is not accepted and must be held by the source.
- Pixel hand-off and a completing beat on the same edge: the new pixel replaces the drained one and pix_valid stays 1.
- Error pulses are registered and assert the edge after the offending beat is accepted. They are not asserted in the cycle after reset.
- rst mid-pixel or in STALL discards the accumulator and output register. No pixel is emitted.

## Test plan
- Order R=0x11, G=0x22, B=0x33 on consecutive cycles with pix_ready=1 -> pix_valid for 1 cycle, r/g/b_out=11/22/33, one cycle after the B beat.
- STRICT_ORDER=0: beats B=0x0C, R=0x0A, G=0x0B -> pixel 0A/0B/0C. Beats R=0x01, R=0x05, G, B -> dup_err pulses once, r_out=0x05.
- pix_ready=0, send two full pixels (6 beats) -> pixel 1 held stable, ch_ready=0 after the 6th beat. Raise pix_ready for 1 cycle -> pixel 2 on outputs, ch_ready=1 next cycle, no data lost.
- ch_sel=11 beat mid-pixel -> sel_err pulse, mask unchanged, pixel completes with the subsequent G/B.
- STRICT_ORDER=1: R, B -> seq_err, no pixel. Then R, G, B -> a correct pixel. G first -> seq_err.
- Assert rst for 1 cycle during STALL -> all outputs 0, ch_ready=0 then 1. A subsequent R/G/B produces only the new pixel.
